// File: rtl/melody_player.sv
// Melody sequencer: walks a runtime-writable note table and drives a square-wave tone
// on a single audio pin, with start/stop, looping, rests and an end-of-song marker.
module melody_player #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int BEAT_HZ = 16,
  parameter int DEPTH   = 64,
  parameter int DIV_W   = 20,
  parameter int DUR_W   = 6,
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [DIV_W+DUR_W-1:0] wr_data,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   loop,
  output logic                   audio,
  output logic                   busy,
  output logic                   done,
  output logic [AW-1:0]          note_idx
);

  localparam int BEAT_DIV = CLK_HZ / BEAT_HZ;
  localparam int PW = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
  localparam logic [PW-1:0]    PRE_MAX  = PW'(BEAT_DIV - 1);
  localparam logic [AW-1:0]    LAST_IDX = AW'(DEPTH - 1);
  localparam logic [AW-1:0]    IDX_ONE  = AW'(1);
  localparam logic [DUR_W-1:0] DUR_ONE  = DUR_W'(1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  typedef enum logic [1:0] {IDLE, FETCH, PLAY} state_t;

  state_t state, state_next;

  logic [DIV_W+DUR_W-1:0] mem [DEPTH];
  logic [DIV_W-1:0]       entry_hp;
  logic [DUR_W-1:0]       entry_dur;
  logic [DIV_W-1:0]       half_period;
  logic [DUR_W-1:0]       dur;
  logic [DIV_W-1:0]       tone_cnt;
  logic [PW-1:0]          beat_pre;
  logic [DUR_W-1:0]       beat_cnt;
  logic                   note_over;
  logic                   load;
  logic                   advance;
  logic                   song_end;

  // Table has no reset; only the write port is clocked, reads are combinational.
  always_ff @(posedge clock) begin
    if (wr_en)
      mem[wr_addr] <= wr_data;
  end

  assign {entry_hp, entry_dur} = mem[note_idx];
  assign note_over = (beat_pre == PRE_MAX) && (beat_cnt == dur - DUR_ONE);
  assign busy = (state != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // song_end covers both an explicit end marker and running off the last table entry.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    advance    = 1'b0;
    song_end   = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop)
          state_next = FETCH;
      end
      FETCH: begin
        if (entry_dur == '0) begin
          song_end = 1'b1;
        end else begin
          load       = 1'b1;
          state_next = PLAY;
        end
      end
      PLAY: begin
        if (note_over) begin
          if (note_idx == LAST_IDX) begin
            song_end = 1'b1;
          end else begin
            advance    = 1'b1;
            state_next = FETCH;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (song_end)
      state_next = loop ? FETCH : IDLE;
    if (stop)
      state_next = IDLE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      note_idx    <= '0;
      half_period <= '0;
      dur         <= '0;
      tone_cnt    <= '0;
      beat_pre    <= '0;
      beat_cnt    <= '0;
      audio       <= 1'b0;
      done        <= 1'b0;
    end else if (stop) begin
      note_idx <= '0;
      tone_cnt <= '0;
      beat_pre <= '0;
      beat_cnt <= '0;
      audio    <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= song_end && !loop;
      case (state)
        IDLE: begin
          audio <= 1'b0;
          if (start)
            note_idx <= '0;
        end
        FETCH: begin
          if (load) begin
            half_period <= entry_hp;
            dur         <= entry_dur;
            tone_cnt    <= '0;
            beat_pre    <= '0;
            beat_cnt    <= '0;
            audio       <= 1'b0;
          end else if (song_end && loop) begin
            note_idx <= '0;
          end
        end
        PLAY: begin
          // A zero half-period is a rest: the pin stays low for the whole note.
          if (half_period == '0) begin
            audio <= 1'b0;
          end else if (tone_cnt == half_period - DIV_ONE) begin
            tone_cnt <= '0;
            audio    <= ~audio;
          end else begin
            tone_cnt <= tone_cnt + DIV_ONE;
          end
          if (beat_pre == PRE_MAX) begin
            beat_pre <= '0;
            beat_cnt <= beat_cnt + DUR_ONE;
          end else begin
            beat_pre <= beat_pre + PW'(1);
          end
          if (advance) begin
            note_idx <= note_idx + IDX_ONE;
            audio    <= 1'b0;
          end else if (song_end) begin
            audio <= 1'b0;
            if (loop)
              note_idx <= '0;
          end
        end
        default: audio <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_melody_player.sv
// Directed bench for melody_player with BEAT_DIV=10 and a 4-entry table; cycle k is
// counted from the edge that samples start (k=0 is the FETCH cycle of entry 0).
module tb_melody_player;

  localparam int AW    = 2;
  localparam int DIV_W = 20;
  localparam int DUR_W = 6;

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   wr_en;
  logic [AW-1:0]          wr_addr;
  logic [DIV_W+DUR_W-1:0] wr_data;
  logic                   start;
  logic                   stop;
  logic                   loop;
  logic                   audio;
  logic                   busy;
  logic                   done;
  logic [AW-1:0]          note_idx;

  int vectors     = 0;
  int miscompares = 0;
  int waited;

  always #5 clock = ~clock;

  melody_player #(
    .CLK_HZ (1000),
    .BEAT_HZ(100),
    .DEPTH  (4),
    .DIV_W  (DIV_W),
    .DUR_W  (DUR_W)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .start   (start),
    .stop    (stop),
    .loop    (loop),
    .audio   (audio),
    .busy    (busy),
    .done    (done),
    .note_idx(note_idx)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic writeEntry(input int addr, input int hp, input int d);
    logic [DIV_W-1:0] hpv;
    logic [DUR_W-1:0] dv;
    hpv     = DIV_W'(hp);
    dv      = DUR_W'(d);
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    wr_data = {hpv, dv};
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic applyStimulus(input logic st, input logic sp, input logic lp);
    start = st;
    stop  = sp;
    loop  = lp;
    tick();
    start = 1'b0;
    stop  = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    start   = 1'b0;
    stop    = 1'b0;
    loop    = 1'b0;
    tick(2);
    checkOutput("reset_audio", audio, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_idx", note_idx, 0);
    reset = 1'b0;

    $display("[TB] basic song");
    writeEntry(0, 2, 3);
    writeEntry(1, 0, 2);
    writeEntry(2, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("basic_busy", busy, 1);
    checkOutput("basic_idx0", note_idx, 0);
    for (int k = 1; k <= 30; k++) begin
      tick();
      checkOutput("basic_tone", audio, ((k - 1) >> 1) & 1);
    end
    for (int k = 31; k <= 52; k++) begin
      tick();
      checkOutput("basic_rest", audio, 0);
      if (k == 32) checkOutput("basic_idx1", note_idx, 1);
    end
    checkOutput("basic_idx2", note_idx, 2);
    checkOutput("basic_nodone", done, 0);
    tick();
    checkOutput("basic_done", done, 1);
    checkOutput("basic_idle", busy, 0);
    tick();
    checkOutput("basic_done_pulse", done, 0);

    $display("[TB] loop mode");
    applyStimulus(1'b1, 1'b0, 1'b1);
    tick(52);
    checkOutput("loop_idx2", note_idx, 2);
    tick();
    checkOutput("loop_restart_idx", note_idx, 0);
    checkOutput("loop_busy", busy, 1);
    checkOutput("loop_nodone", done, 0);
    loop = 1'b0;
    tick(3);
    checkOutput("loop_tone", audio, 1);
    waited = 0;
    while (!done && waited < 200) begin
      tick();
      waited++;
    end
    checkOutput("loop_finish_cycles", waited, 50);
    tick();
    checkOutput("loop_idle", busy, 0);

    $display("[TB] wrap past last entry");
    for (int i = 0; i < 4; i++) writeEntry(i, 1, 1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick(2);
    checkOutput("wrap_tone_hi", audio, 1);
    tick();
    checkOutput("wrap_tone_lo", audio, 0);
    tick(9);
    checkOutput("wrap_idx1", note_idx, 1);
    tick(22);
    checkOutput("wrap_idx3", note_idx, 3);
    tick(9);
    checkOutput("wrap_nodone", done, 0);
    tick();
    checkOutput("wrap_done", done, 1);
    checkOutput("wrap_idx_end", note_idx, 3);
    checkOutput("wrap_idle", busy, 0);

    $display("[TB] wrap with loop, then stop+start");
    applyStimulus(1'b1, 1'b0, 1'b1);
    tick(44);
    checkOutput("wrap_loop_idx", note_idx, 0);
    checkOutput("wrap_loop_busy", busy, 1);
    checkOutput("wrap_loop_nodone", done, 0);
    tick(3);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("stop_busy", busy, 0);
    checkOutput("stop_audio", audio, 0);
    checkOutput("stop_done", done, 0);
    tick();
    checkOutput("stop_stays_idle", busy, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("restart_busy", busy, 1);
    checkOutput("restart_idx", note_idx, 0);
    tick(12);
    checkOutput("restart_idx1", note_idx, 1);
    tick();
    checkOutput("prereset_audio", audio, 1);

    $display("[TB] async reset mid-note");
    #2 reset = 1'b1;
    #1;
    checkOutput("areset_audio", audio, 0);
    checkOutput("areset_busy", busy, 0);
    checkOutput("areset_idx", note_idx, 0);
    tick();
    reset = 1'b0;
    tick(3);
    checkOutput("areset_no_resume", busy, 0);
    checkOutput("areset_audio_idle", audio, 0);

    $display("[TB] live table write");
    writeEntry(0, 2, 3);
    writeEntry(1, 0, 2);
    writeEntry(2, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick(4);
    checkOutput("live_tone0", audio, 1);
    writeEntry(1, 3, 1);
    tick(26);
    checkOutput("live_idx1", note_idx, 1);
    for (int k = 32; k <= 41; k++) begin
      tick();
      checkOutput("live_tone1", audio, ((k - 32) / 3) % 2);
    end
    tick();
    checkOutput("live_idx2", note_idx, 2);
    tick();
    checkOutput("live_done", done, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
